// File: rtl/weight_load_control_unit_if.sv
// ---------------------------------------------------------------------------
// weight_load_control_unit_if
// Purpose : bundles the instruction, weight-memory read and shadow-buffer
//           write signals of the weight load control unit.
// Signals : start_i, U_dim_i[7:0], weight_base_addr_i[15:0],
//           next_weight_tile_i                          (into the unit)
//           weight_mem_rd_en_o, weight_mem_addr_o[15:0],
//           weight_row_wr_en_o, weight_row_idx_o[4:0],
//           compute_weights_rdy_o, busy_o, done_o, error_o (out of the unit)
// Modports: slave  - the control unit itself
//           master - the sequencer / memory / consumer side
// ---------------------------------------------------------------------------
interface weight_load_control_unit_if;
  logic        start_i;
  logic [7:0]  U_dim_i;
  logic [15:0] weight_base_addr_i;
  logic        next_weight_tile_i;
  logic        weight_mem_rd_en_o;
  logic [15:0] weight_mem_addr_o;
  logic        weight_row_wr_en_o;
  logic [4:0]  weight_row_idx_o;
  logic        compute_weights_rdy_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  modport slave (
    input  start_i, U_dim_i, weight_base_addr_i, next_weight_tile_i,
    output weight_mem_rd_en_o, weight_mem_addr_o, weight_row_wr_en_o,
           weight_row_idx_o, compute_weights_rdy_o, busy_o, done_o, error_o
  );

  modport master (
    output start_i, U_dim_i, weight_base_addr_i, next_weight_tile_i,
    input  weight_mem_rd_en_o, weight_mem_addr_o, weight_row_wr_en_o,
           weight_row_idx_o, compute_weights_rdy_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/weight_load_control_unit.sv
// ---------------------------------------------------------------------------
// weight_load_control_unit
// Purpose : streams weight tiles (MUL_SIZE rows each) from weight memory into
//           the systolic array's shadow buffer, one tile at a time, handing
//           each full tile to the consumer and waiting for it to be swapped
//           in before fetching the next one.
// Ports   : clk_i  - rising-edge clock
//           rst_ni - asynchronous active-low reset
//           bus    - weight_load_control_unit_if.slave (instruction, memory
//                    read, shadow-buffer write and status signals)
// Params  : MUL_SIZE - rows per tile / array dimension (32)
// Options : `define WLCU_PROTOCOL_CHECK_EN to enable the sticky error_o flag
//           raised by next_weight_tile_i outside FULL. Undefined, error_o
//           is tied to 0.
// Timing  : start sampled at edge E0 -> reads issued on E1..E32, shadow
//           writes on E2..E33 (DRAIN cycle shows the last write), tile ready
//           on E34.
// ---------------------------------------------------------------------------
module weight_load_control_unit #(
  parameter int unsigned MUL_SIZE = 32
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  weight_load_control_unit_if.slave bus
);

  localparam int unsigned ROW_W = $clog2(MUL_SIZE);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MUL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FULL} state_e;

  state_e           state_q;
  logic [2:0]       tiles_q;     // tiles in this instruction
  logic [2:0]       tile_q;      // tile currently being fetched/held
  logic [15:0]      base_q;
  logic [ROW_W-1:0] row_q;       // next row to issue
  logic [ROW_W-1:0] rd_row_q;    // row of the read on the bus this cycle
  logic             last_q;      // final row of the tile already issued
  logic             rd_en_q;
  logic [15:0]      addr_q;
  logic             wr_en_q;
  logic [ROW_W-1:0] wr_idx_q;
  logic             rdy_q;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       tiles_in_d;
  logic [3:0]       tile_inc_d;
  logic             more_tiles_d;

  // NOTE: every always_comb output gets a default first so no latch can form.
  always_comb begin
    tiles_in_d   = 3'(bus.U_dim_i >> ROW_W);
    tile_inc_d   = {1'b0, tile_q} + 4'd1;
    more_tiles_d = tile_inc_d < {1'b0, tiles_q};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  // NOTE: all registers here are control state and are reset; there is no
  // storage array that would need to be left unreset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      tiles_q  <= '0;
      tile_q   <= '0;
      base_q   <= '0;
      row_q    <= '0;
      rd_row_q <= '0;
      last_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      wr_en_q  <= 1'b0;
      wr_idx_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      // Memory returns data one cycle after the read, so the shadow-buffer
      // write is simply the read strobe and row delayed by one cycle.
      wr_en_q  <= rd_en_q;
      wr_idx_q <= rd_row_q;

      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (tiles_in_d == 3'd0) begin
              done_q <= 1'b1;
            end else begin
              tiles_q <= tiles_in_d;
              base_q  <= bus.weight_base_addr_i;
              tile_q  <= '0;
              row_q   <= '0;
              last_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= FETCH;
            end
          end
        end

        FETCH: begin
          if (!last_q) begin
            rd_en_q  <= 1'b1;
            // tile*MUL_SIZE + row is just the concatenation; the sum wraps
            // modulo 2^16 by width.
            addr_q   <= base_q + 16'({tile_q, row_q});
            rd_row_q <= row_q;
            row_q    <= row_q + 1'b1;   // wraps to 0 after the last row
            if (row_q == ROW_LAST) last_q <= 1'b1;
          end else begin
            rd_en_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= DRAIN;
          end
        end

        DRAIN: begin
          rdy_q   <= 1'b1;
          state_q <= FULL;
        end

        FULL: begin
          if (bus.next_weight_tile_i) begin
            rdy_q  <= 1'b0;
            tile_q <= tile_inc_d[2:0];
            if (more_tiles_d) begin
              state_q <= FETCH;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WLCU_PROTOCOL_CHECK_EN
  logic error_q;

  // Observes only; the FSM above never looks at this flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
    end else if (bus.next_weight_tile_i && (state_q != FULL)) begin
      error_q <= 1'b1;
    end
  end

  assign bus.error_o = error_q;
`else
  assign bus.error_o = 1'b0;
`endif

  assign bus.weight_mem_rd_en_o    = rd_en_q;
  assign bus.weight_mem_addr_o     = addr_q;
  assign bus.weight_row_wr_en_o    = wr_en_q;
  assign bus.weight_row_idx_o      = 5'(wr_idx_q);
  assign bus.compute_weights_rdy_o = rdy_q;
  assign bus.busy_o                = busy_q;
  assign bus.done_o                = done_q;

endmodule

// File: doc/weight_load_control_unit.md
WEIGHT_LOAD_CONTROL_UNIT -- requirements
Module: weight_load_control_unit

Interface
REQ-001 Parameter MUL_SIZE, default 32 (from tpu_package), meaning rows per weight tile and width of one systolic-array dimension.
REQ-002 One clock; reset is asynchronous and active-low. Ports:
REQ-003 clk_i  input  1  rising-edge clock.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  load-weights instruction strobe; sampled only in IDLE.
REQ-006 U_dim_i  input  8  output dimension; tile count = U_dim_i >> 5, latched at start.
REQ-007 weight_base_addr_i  input  16  weight memory base address, latched at start.
REQ-008 next_weight_tile_i  input  1  consumer has swapped in the shadow tile; shadow buffer is now free.
REQ-009 weight_mem_rd_en_o  output  1  weight memory read strobe; memory read latency is 1 cycle.
REQ-010 weight_mem_addr_o  output  16  weight memory read address.
REQ-011 weight_row_wr_en_o  output  1  shadow-buffer row write strobe; equals weight_mem_rd_en_o delayed one cycle.
REQ-012 weight_row_idx_o  output  5  shadow-buffer row written; equals the row counter delayed one cycle.
REQ-013 compute_weights_rdy_o  output  1  shadow buffer holds a complete, unconsumed tile.
REQ-014 busy_o  output  1  high in every state except IDLE.
REQ-015 done_o  output  1  one-cycle pulse when the instruction completes.
REQ-016 error_o  output  1  sticky protocol-violation flag (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DRAIN, FULL; all outputs registered.
REQ-018 IDLE: start_i=1 with tile count 0 SHALL pulse done_o next cycle, issue no reads, stay IDLE.
REQ-019 IDLE: start_i=1 with tile count >0 SHALL latch count and base, clear tile and row counters, enter FETCH.
REQ-020 FETCH: each cycle SHALL assert weight_mem_rd_en_o with addr = base + tile*32 + row (16-bit, modulo 2^16), row incrementing 0..31.
REQ-021 After row 31 is issued, FSM SHALL enter DRAIN for one cycle (last row write), then FULL.
REQ-022 compute_weights_rdy_o SHALL rise on entry to FULL, 34 cycles after the edge sampling start_i.
REQ-023 FULL: next_weight_tile_i=1 SHALL deassert compute_weights_rdy_o on that edge and increment the tile counter.
REQ-024 FULL: after the increment, if tiles remain, FSM SHALL enter FETCH for the next tile; otherwise pulse done_o and enter IDLE.
REQ-025 next_weight_tile_i outside FULL SHALL be ignored by the FSM.
REQ-026 start_i outside IDLE SHALL be ignored; latched U_dim/base SHALL NOT change mid-instruction.
REQ-027 Row counter SHALL wrap 31->0 only at tile boundaries; the tile counter is 3 bits (max 7 tiles).

Reset
REQ-028 rst_ni low SHALL immediately force IDLE and drive all outputs and counters to 0, including mid-FETCH or mid-DRAIN.
REQ-029 After rst_ni deasserts, the first accepted start_i SHALL behave identically to power-up.

Configuration
REQ-030 Macro WLCU_PROTOCOL_CHECK_EN defined: error_o SHALL set on next_weight_tile_i=1 while not in FULL, and stay set until reset; FSM behaviour SHALL be unaffected.
REQ-031 Macro WLCU_PROTOCOL_CHECK_EN undefined: error_o SHALL be constant 0, with no check logic.

Verification
REQ-032 U_dim=64, base=0x0100, start -> reads 0x0100..0x011F, rdy at cycle 34; next_tile -> reads 0x0120..0x013F; next_tile -> done_o pulse, IDLE.
REQ-033 U_dim=31, start -> done_o pulse next cycle, zero reads, busy_o stays 0.
REQ-034 U_dim=32, base=0xFFF0 -> addresses 0xFFF0..0xFFFF then 0x0000..0x000F; row_idx 0..31 lag rd_en by 1 cycle.
REQ-035 rst_ni low during row 10 of FETCH -> all outputs 0 at once; after release, start with U_dim=32 -> full 32-row fetch from row 0.
REQ-036 With WLCU_PROTOCOL_CHECK_EN, next_tile pulse during FETCH -> error_o=1 sticky, fetch completes unchanged; without the macro -> error_o=0.
REQ-037 start_i pulsed in FULL with a new base -> ignored; next fetch uses the original base.
